program_loader: RTL and testbench
=================================

# program_loader

Byte-stream writer that fills the MIPS instruction memory (RAM variant of the program memory) before the core runs. A host streams a framed image (length, little-endian instruction words, checksum) over a valid/ready byte interface; the loader assembles 32-bit words and issues one write per word at byte addresses starting at the text base 0x00400000. It holds the core in reset (CpuHold) until a complete, checksum-valid image has been written.

## Interface
- MEMORY_DEPTH, 1024, instruction-memory depth in words; maximum accepted image length
- DATA_WIDTH, 32, instruction and address width
- BASE_ADDRESS, 32'h0040_0000, byte address of word 0
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- Start  input  1  single-cycle request to begin a load
- ByteIn  input  8  stream byte
- ByteValid  input  1  ByteIn is valid
- ByteReady  output  1  loader accepts ByteIn this cycle
- MemWrite  output  1  one-cycle write strobe to instruction memory
- WriteAddress  output  DATA_WIDTH  byte address, BASE_ADDRESS + 4*index
- WriteData  output  DATA_WIDTH  assembled instruction word
- Busy  output  1  load in progress
- Done  output  1  image loaded and checksum verified (sticky)
- Error  output  1  length or checksum fault (sticky)
- CpuHold  output  1  keep processor in reset

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N), then N×4 data bytes (each word LSB first), then CHK byte. CHK equals XOR of all preceding frame bytes.
- Byte accepted on cycle where ByteValid && ByteReady. ByteReady=1 only in LEN_LO, LEN_HI, DATA, CHECK states.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + Start -> LEN_LO; clears Done, Error, index, byte counter, running XOR; sets CpuHold=1. Start ignored in all other states.
- LEN_LO -> LEN_HI on accept. LEN_HI on accept: N==0 or N>MEMORY_DEPTH -> ERROR; else -> DATA.
- DATA: shift byte into word at lane byte_cnt (0..3); on 4th accept -> WRITE.
- WRITE (exactly one cycle): MemWrite=1, WriteAddress=BASE_ADDRESS+(index<<2), WriteData=word; index+1; index+1==N -> CHECK else DATA.
- CHECK on accept: running XOR (incl. CHK byte) ==0 -> DONE else ERROR.
- DONE: Done=1, CpuHold=0. ERROR: Error=1, CpuHold=1. Both held until Start or reset.
- Running XOR covers every accepted byte from LEN_LO through CHK.
- Words already written before an ERROR remain in memory; no rollback.
- Busy=1 in LEN_LO..CHECK.

## Timing
- All outputs registered. Reset values: ByteReady=0, MemWrite=0, WriteAddress=BASE_ADDRESS, WriteData=0, Busy=0, Done=0, Error=0, CpuHold=1; state IDLE.
- Start at cycle t -> ByteReady=1 at t+1.
- 4th byte of a word accepted at t -> MemWrite=1 at t+1 only; ByteReady=0 during that cycle; ByteReady=1 at t+2. Minimum 5 cycles/word.
- CHK accepted at t -> Done or Error =1 and CpuHold updated at t+1.
- ByteValid gaps: state holds indefinitely, no timeout.
- reset mid-frame: next cycle all outputs at reset values, partial word discarded, MemWrite never asserted after reset edge.
- Start coincident with reset: reset wins.
- index width: clog2(MEMORY_DEPTH)+1; N compared on full 16 bits.

## Test plan
- Bytes 01 00 05 00 08 20 2C -> one MemWrite, WriteAddress=0x00400000, WriteData=0x20080005; Done=1, CpuHold=0, Error=0.
- N=2, words 0x20080005, 0x00000000, correct CHK -> writes at 0x00400000 then 0x00400004; Done=1.
- Bytes 00 00 -> Error=1 after LEN_HI, no MemWrite, CpuHold=1; then Start + valid frame -> Error clears, Done=1.
- Bytes 01 04 (N=1025, default depth) -> Error=1, ByteReady=0, no MemWrite.
- First frame with CHK=0x2D -> word written at 0x00400000, Error=1, Done=0, CpuHold=1.
- Random ByteValid gaps plus reset after 2nd data byte -> outputs return to reset values next cycle, no MemWrite; subsequent full frame loads correctly.

Source files
------------

// File: rtl/program_loader.sv
// ============================================================================
//  Module   : program_loader
//  Function : Framed byte-stream loader for the MIPS instruction RAM; holds the
//             core in reset until a checksum-valid image has been written.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
   parameter int                     MEMORY_DEPTH = 1024,
   parameter int                     DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0]  BASE_ADDRESS = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start,
   input  logic [7:0]            ByteIn,
   input  logic                  ByteValid,
   output logic                  ByteReady,
   output logic                  MemWrite,
   output logic [DATA_WIDTH-1:0] WriteAddress,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Error,
   output logic                  CpuHold
);

   localparam int IDX_W = $clog2(MEMORY_DEPTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CHECK  = 3'd5,
      S_DONE   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   state_t                  state;
   logic [15:0]             len;
   logic [IDX_W-1:0]        index;
   logic [1:0]              byte_cnt;
   logic [DATA_WIDTH-1:0]   word;
   logic [7:0]              xor_acc;

   logic                    accept;
   logic [15:0]             len_full;
   logic [7:0]              xor_next;
   logic [IDX_W-1:0]        next_index;
   logic                    last_word;
   logic                    len_bad;
   logic [DATA_WIDTH-1:0]   assembled;

   assign accept     = ByteValid && ByteReady;
   assign len_full   = {ByteIn, len[7:0]};
   assign xor_next   = xor_acc ^ ByteIn;
   assign next_index = index + 1'b1;
   assign last_word  = (16'(next_index) == len);
   assign len_bad    = (len_full == 16'd0) || (32'(len_full) > MEMORY_DEPTH);

   // Word as it will look once the current byte lands in its lane.
   always_comb begin
      assembled = word;
      assembled[{byte_cnt, 3'b000} +: 8] = ByteIn;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         len          <= '0;
         index        <= '0;
         byte_cnt     <= '0;
         word         <= '0;
         xor_acc      <= '0;
         ByteReady    <= 1'b0;
         MemWrite     <= 1'b0;
         WriteAddress <= BASE_ADDRESS;
         WriteData    <= '0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         Error        <= 1'b0;
         CpuHold      <= 1'b1;
      end else begin
         MemWrite <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (Start) begin
                  state     <= S_LEN_LO;
                  index     <= '0;
                  byte_cnt  <= '0;
                  xor_acc   <= '0;
                  Done      <= 1'b0;
                  Error     <= 1'b0;
                  CpuHold   <= 1'b1;
                  Busy      <= 1'b1;
                  ByteReady <= 1'b1;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= ByteIn;
                  xor_acc  <= xor_next;
                  state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  len     <= len_full;
                  xor_acc <= xor_next;
                  if (len_bad) begin
                     state     <= S_ERROR;
                     ByteReady <= 1'b0;
                     Busy      <= 1'b0;
                     Error     <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  word     <= assembled;
                  xor_acc  <= xor_next;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     // Write strobe is raised for the single WRITE cycle.
                     state        <= S_WRITE;
                     ByteReady    <= 1'b0;
                     MemWrite     <= 1'b1;
                     WriteAddress <= BASE_ADDRESS + (DATA_WIDTH'(index) << 2);
                     WriteData    <= assembled;
                  end
               end
            end
            S_WRITE: begin
               index     <= next_index;
               ByteReady <= 1'b1;
               state     <= last_word ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
               if (accept) begin
                  xor_acc   <= xor_next;
                  ByteReady <= 1'b0;
                  Busy      <= 1'b0;
                  if (xor_next == 8'h00) begin
                     state   <= S_DONE;
                     Done    <= 1'b1;
                     CpuHold <= 1'b0;
                  end else begin
                     state   <= S_ERROR;
                     Error   <= 1'b1;
                     CpuHold <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
//  Module   : tb_program_loader
//  Function : Randomised scoreboard bench for program_loader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        MemWrite;
   logic [31:0] WriteAddress;
   logic [31:0] WriteData;
   logic        Busy;
   logic        Done;
   logic        Error;
   logic        CpuHold;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   program_loader #(
      .MEMORY_DEPTH (DEPTH),
      .DATA_WIDTH   (32),
      .BASE_ADDRESS (BASE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Start        (Start),
      .ByteIn       (ByteIn),
      .ByteValid    (ByteValid),
      .ByteReady    (ByteReady),
      .MemWrite     (MemWrite),
      .WriteAddress (WriteAddress),
      .WriteData    (WriteData),
      .Busy         (Busy),
      .Done         (Done),
      .Error        (Error),
      .CpuHold      (CpuHold)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      if (MemWrite === 1'b1) begin
         checks++;
         if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                     WriteAddress, WriteData);
         end else begin
            logic [31:0] ea, ed;
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            if (WriteAddress !== ea || WriteData !== ed) begin
               errors++;
               $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                        WriteAddress, WriteData, ea, ed);
            end
         end
         chk("ready_during_write", {31'd0, ByteReady}, 32'd0);
      end
   end

   task automatic check_flags(input string tag, input bit rdy, input bit busy,
                              input bit done, input bit err, input bit hold);
      chk({tag, "_ByteReady"}, {31'd0, ByteReady}, {31'd0, rdy});
      chk({tag, "_Busy"},      {31'd0, Busy},      {31'd0, busy});
      chk({tag, "_Done"},      {31'd0, Done},      {31'd0, done});
      chk({tag, "_Error"},     {31'd0, Error},     {31'd0, err});
      chk({tag, "_CpuHold"},   {31'd0, CpuHold},   {31'd0, hold});
   endtask

   task automatic check_reset_values(input string tag);
      check_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk({tag, "_MemWrite"},     {31'd0, MemWrite}, 32'd0);
      chk({tag, "_WriteAddress"}, WriteAddress,      BASE);
      chk({tag, "_WriteData"},    WriteData,         32'd0);
   endtask

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      int gap;
      ok  = 1'b0;
      gap = $urandom_range(0, 2);
      ByteValid = 1'b0;
      repeat (gap) begin
         ByteIn = 8'($urandom);
         @(negedge clk);
      end
      ByteIn    = b;
      ByteValid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (ByteReady) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      ByteValid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_addr.delete();
      exp_data.delete();
      @(negedge clk);
   endtask

   task automatic do_start();
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      check_flags("start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   // Reference model: builds the frame from the rules and predicts the outcome.
   task automatic load_frame(input string tag, input int n, input logic [31:0] w[$],
                             input logic [7:0] chk_flip);
      logic [7:0] q[$];
      logic [7:0] x;
      bit         len_err;
      bit         ok;
      do_start();
      q.push_back(n[7:0]);
      q.push_back(n[15:8]);
      len_err = (n == 0) || (n > DEPTH);
      if (!len_err) begin
         for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) q.push_back(w[i][8*j +: 8]);
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back(w[i]);
         end
         x = 8'h00;
         foreach (q[i]) x ^= q[i];
         q.push_back(x ^ chk_flip);
      end
      foreach (q[i]) begin
         send_byte(q[i], ok);
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got no accept of byte %0d, expected accept", tag, i);
            do_reset();
            return;
         end
      end
      if (len_err || chk_flip != 8'h00)
         check_flags(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      else
         check_flags(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk({tag, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] w[$];
      bit          ok;
      reset     = 1'b1;
      Start     = 1'b0;
      ByteIn    = 8'h00;
      ByteValid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("idle");

      w = {32'h2008_0005};
      load_frame("one_word", 1, w, 8'h00);

      w = {32'h2008_0005, 32'h0000_0000};
      load_frame("two_words", 2, w, 8'h00);

      w = {};
      load_frame("len_zero", 0, w, 8'h00);
      w = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
      load_frame("after_error", 3, w, 8'h00);

      w = {};
      load_frame("len_1025", 1025, w, 8'h00);

      w = {32'h2008_0005};
      load_frame("bad_chk", 1, w, 8'h01);

      // Reset after the second data byte: partial word must be dropped.
      do_start();
      send_byte(8'h01, ok);
      send_byte(8'h00, ok);
      send_byte(8'h05, ok);
      send_byte(8'h00, ok);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("mid_reset");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("post_reset");
      w = {32'hCAFE_F00D, 32'h1234_5678};
      load_frame("reload", 2, w, 8'h00);

      for (int f = 0; f < 8; f++) begin
         int          n;
         logic [7:0]  flip;
         n = $urandom_range(1, 6);
         w = {};
         for (int i = 0; i < n; i++) w.push_back($urandom);
         flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         load_frame($sformatf("rand%0d", f), n, w, flip);
      end

      w = {};
      for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
      load_frame("max_depth", DEPTH, w, 8'h00);

      repeat (3) @(negedge clk);
      chk("final_pending_writes", 32'(exp_addr.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
